// File: rtl/mux8_scan_pkg.sv
// Shared types and constants for the 8:1 mux scan sequencer.
// Start/end index helpers keep the bit-order choice in one place.
package mux8_scan_pkg;

    localparam int IDX_W    = 3;
    localparam int NUM_BITS = 8;
    localparam int WCNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    function automatic logic [IDX_W-1:0] start_idx(input logic lsb_first);
        return lsb_first ? '0 : IDX_W'(NUM_BITS - 1);
    endfunction

    function automatic logic [IDX_W-1:0] end_idx(input logic lsb_first);
        return lsb_first ? IDX_W'(NUM_BITS - 1) : '0;
    endfunction

endpackage

// File: rtl/mux8_scan_idx.sv
// 3-bit select index: clear to 0, load the word's start position, or step
// one position toward the end position. `last` flags the final position.
module mux8_scan_idx
    import mux8_scan_pkg::*;
#(
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic             step,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    localparam logic [IDX_W-1:0] START = start_idx(LSB_FIRST != 0);
    localparam logic [IDX_W-1:0] STOP  = end_idx(LSB_FIRST != 0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (load) begin
            idx <= START;
        end else if (step) begin
            if (LSB_FIRST != 0) begin
                idx <= idx + IDX_W'(1);
            end else begin
                idx <= idx - IDX_W'(1);
            end
        end
    end

    assign last = (idx == STOP);

endmodule

// File: rtl/mux8_scan_ctrl.sv
// Sequencer feeding an external 8:1 mux: holds an accepted byte on d_out and
// walks the select through all eight positions, one per downstream beat.
module mux8_scan_ctrl
    import mux8_scan_pkg::*;
#(
    parameter int LSB_FIRST = 1,
    parameter int IDLE_GAP  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              flush,
    input  logic              out_ready,
    output logic [7:0]        d_out,
    output logic              sel_a,
    output logic              sel_b,
    output logic              sel_c,
    output logic              bit_valid,
    output logic              bit_last,
    output logic [WCNT_W-1:0] word_cnt,
    output state_e            fsm_state
);

    localparam logic [2:0] GAP_END = 3'(IDLE_GAP - 1);

    state_e           state;
    logic [2:0]       gap_cnt;
    logic [IDX_W-1:0] idx;
    logic             idx_last;
    logic             accept;
    logic             beat;
    logic             last_beat;
    logic             idx_clear;
    logic             idx_step;

    // Handshakes: a word moves when in_valid && in_ready on a rising edge; a bit
    // moves when bit_valid && out_ready. Neither ready depends on its own valid.
    assign in_ready  = !flush &&
                       ((state == IDLE) ||
                        ((IDLE_GAP == 0) && (state == SHIFT) && idx_last && out_ready));
    assign accept    = in_valid && in_ready;
    assign beat      = bit_valid && out_ready;
    assign last_beat = beat && idx_last;

    // A last beat without a follow-on word parks the select at 000.
    assign idx_clear = flush || (last_beat && !accept);
    assign idx_step  = beat && !idx_last;

    mux8_scan_idx #(
        .LSB_FIRST(LSB_FIRST)
    ) u_idx (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (idx_clear),
        .load  (accept),
        .step  (idx_step),
        .idx   (idx),
        .last  (idx_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            d_out     <= '0;
            bit_valid <= 1'b0;
            word_cnt  <= '0;
            gap_cnt   <= '0;
        end else if (flush) begin
            // Abort drops the word but keeps d_out so the mux inputs stay quiet.
            state     <= IDLE;
            bit_valid <= 1'b0;
            gap_cnt   <= '0;
        end else begin
            if (accept) begin
                d_out <= in_data;
            end
            if (last_beat) begin
                word_cnt <= word_cnt + WCNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= SHIFT;
                        bit_valid <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (last_beat && !accept) begin
                        bit_valid <= 1'b0;
                        gap_cnt   <= '0;
                        state     <= (IDLE_GAP > 0) ? GAP : IDLE;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 3'd1;
                    if (gap_cnt == GAP_END) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    bit_valid <= 1'b0;
                end
            endcase
        end
    end

    assign {sel_a, sel_b, sel_c} = idx;
    assign bit_last              = bit_valid && idx_last;
    assign fsm_state             = state;

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// Bench for mux8_scan_ctrl: three configurations (LSB-first, MSB-first, LSB-first
// with a 3-cycle gap) share stimulus; each task focuses on one instance via sel_dut.
module tb_mux8_scan_ctrl;
    import mux8_scan_pkg::*;

    localparam int W = 13;  // {d_out, bit_last, sel, mux bit}

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       flush = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic       in_ready_v[3];
    logic [7:0] d_out_v[3];
    logic       sa_v[3], sb_v[3], sc_v[3], bv_v[3], bl_v[3], mux_v[3];
    logic [7:0] wc_v[3];
    state_e     st_v[3];

    int         sel_dut = 0;
    logic       cur_ready, cur_valid, cur_last, cur_mux;
    logic [2:0] cur_sel;
    logic [7:0] cur_dout, cur_wcnt;
    state_e     cur_state;

    logic [W-1:0] exp_q[$];
    logic [7:0]   words_q[$];
    int checks = 0;
    int errors = 0;
    int valid_cycles, bubbles, gap_low;

    always #5 clk = ~clk;

    mux8_scan_ctrl #(.LSB_FIRST(1), .IDLE_GAP(0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .in_data(in_data), .flush(flush), .out_ready(out_ready), .d_out(d_out_v[0]),
        .sel_a(sa_v[0]), .sel_b(sb_v[0]), .sel_c(sc_v[0]), .bit_valid(bv_v[0]),
        .bit_last(bl_v[0]), .word_cnt(wc_v[0]), .fsm_state(st_v[0])
    );

    mux8_scan_ctrl #(.LSB_FIRST(0), .IDLE_GAP(0)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .in_data(in_data), .flush(flush), .out_ready(out_ready), .d_out(d_out_v[1]),
        .sel_a(sa_v[1]), .sel_b(sb_v[1]), .sel_c(sc_v[1]), .bit_valid(bv_v[1]),
        .bit_last(bl_v[1]), .word_cnt(wc_v[1]), .fsm_state(st_v[1])
    );

    mux8_scan_ctrl #(.LSB_FIRST(1), .IDLE_GAP(3)) u_gap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .in_data(in_data), .flush(flush), .out_ready(out_ready), .d_out(d_out_v[2]),
        .sel_a(sa_v[2]), .sel_b(sb_v[2]), .sel_c(sc_v[2]), .bit_valid(bv_v[2]),
        .bit_last(bl_v[2]), .word_cnt(wc_v[2]), .fsm_state(st_v[2])
    );

    // The 8:1 mux tree the sequencer drives.
    for (genvar g = 0; g < 3; g++) begin : g_mux
        assign mux_v[g] = d_out_v[g][{sa_v[g], sb_v[g], sc_v[g]}];
    end

    always_comb begin
        cur_ready = in_ready_v[sel_dut];
        cur_valid = bv_v[sel_dut];
        cur_last  = bl_v[sel_dut];
        cur_mux   = mux_v[sel_dut];
        cur_sel   = {sa_v[sel_dut], sb_v[sel_dut], sc_v[sel_dut]};
        cur_dout  = d_out_v[sel_dut];
        cur_wcnt  = wc_v[sel_dut];
        cur_state = st_v[sel_dut];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected bit sequence of one word, in order of appearance on the mux output.
    task automatic push_bits(input logic [7:0] w);
        logic [2:0] i;
        for (int k = 0; k < 8; k++) begin
            i = (sel_dut == 1) ? 3'(7 - k) : 3'(k);
            exp_q.push_back({w, (k == 7), i, w[i]});
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        words_q.delete();
    endtask

    // Presents words_q one by one; called at posedge+1.
    task automatic feed(input int budget);
        logic [7:0] w;
        logic [2:0] st;
        int cyc;
        cyc = 0;
        st = (sel_dut == 1) ? 3'd7 : 3'd0;
        while (words_q.size() > 0 && cyc < budget) begin
            w = words_q[0];
            in_valid = 1'b1;
            in_data = w;
            @(negedge clk);
            cyc++;
            if (cur_ready) begin
                push_bits(w);
                void'(words_q.pop_front());
                @(posedge clk);
                #1;
                checks++;
                if ({cur_valid, cur_sel, cur_dout} !== {1'b1, st, w}) begin
                    errors++;
                    $display("FAIL accept_load got %h required %h", {cur_valid, cur_sel, cur_dout}, {1'b1, st, w});
                end
            end else begin
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (words_q.size() != 0) begin
            errors++;
            $display("FAIL feed_timeout got %0d words left required 0", words_q.size());
            words_q.delete();
        end
    endtask

    // Consumes n_beats bits, checking every valid cycle against the queue head.
    task automatic drain(input int n_beats, input bit toggle);
        int beats, cyc, budget;
        bit started;
        logic [W-1:0] obs;
        beats = 0;
        cyc = 0;
        started = 0;
        budget = n_beats * 3 + 40;
        valid_cycles = 0;
        bubbles = 0;
        gap_low = 0;
        while (beats < n_beats && cyc < budget) begin
            @(posedge clk);
            #1;
            out_ready = toggle ? (cur_valid && valid_cycles[0]) : 1'b1;
            @(negedge clk);
            cyc++;
            if (cur_valid) begin
                started = 1;
                valid_cycles++;
                obs = {cur_dout, cur_last, cur_sel, cur_mux};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_bit got %h required none", obs);
                end else begin
                    if (obs !== exp_q[0]) begin
                        errors++;
                        $display("FAIL bit_beat got %h required %h", obs, exp_q[0]);
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        beats++;
                    end
                end
            end else if (started) begin
                bubbles++;
                if (!cur_ready) gap_low++;
            end
        end
        checks++;
        if (beats != n_beats) begin
            errors++;
            $display("FAIL drain_timeout got %0d beats required %0d", beats, n_beats);
        end
    endtask

    task automatic run(input int n_beats, input bit toggle);
        fork
            feed(n_beats * 16 + 40);
            drain(n_beats, toggle);
        join
    endtask

    task automatic check_wcnt(input string name, input logic [7:0] req);
        checks++;
        if (cur_wcnt !== req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, cur_wcnt, req);
        end
    endtask

    task automatic test_reset();
        sel_dut = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cur_valid, cur_last, cur_sel, cur_dout} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h required 0", {cur_valid, cur_last, cur_sel, cur_dout});
        end
        check_wcnt("reset_wcnt", 8'd0);
        checks++;
        if (cur_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state got %0d required %0d", cur_state, IDLE);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cur_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b required 1", cur_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_lsb_first();
        apply_reset();
        sel_dut = 0;
        words_q.push_back(8'hA5);
        run(8, 1'b0);
        @(negedge clk);
        check_wcnt("lsb_wcnt", 8'd1);
    endtask

    task automatic test_msb_first();
        apply_reset();
        sel_dut = 1;
        words_q.push_back(8'h81);
        run(8, 1'b0);
        @(negedge clk);
        check_wcnt("msb_wcnt", 8'd1);
    endtask

    task automatic test_stall();
        apply_reset();
        sel_dut = 0;
        words_q.push_back(8'h5A);
        run(8, 1'b1);
        checks++;
        if (valid_cycles != 16) begin
            errors++;
            $display("FAIL stall_cycles got %0d required 16", valid_cycles);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        sel_dut = 0;
        out_ready = 1'b1;
        words_q.push_back(8'h3C);
        words_q.push_back(8'hC3);
        run(16, 1'b0);
        checks++;
        if (bubbles != 0 || valid_cycles != 16) begin
            errors++;
            $display("FAIL b2b_bubbles got %0d/%0d required 0/16", bubbles, valid_cycles);
        end
        @(negedge clk);
        check_wcnt("b2b_wcnt", 8'd2);
    endtask

    task automatic test_gap();
        apply_reset();
        sel_dut = 2;
        out_ready = 1'b1;
        words_q.push_back(8'h3C);
        words_q.push_back(8'hC3);
        run(16, 1'b0);
        // Three forced gap cycles, then the IDLE accept cycle before the next bit.
        checks++;
        if (gap_low != 3 || bubbles != 4) begin
            errors++;
            $display("FAIL gap_cycles got %0d/%0d required 3/4", gap_low, bubbles);
        end
        @(negedge clk);
        check_wcnt("gap_wcnt", 8'd2);
    endtask

    task automatic test_flush();
        apply_reset();
        sel_dut = 0;
        out_ready = 1'b1;
        words_q.push_back(8'hFF);
        run(4, 1'b0);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if ({cur_ready, cur_valid, cur_sel} !== {1'b0, 1'b1, 3'd4}) begin
            errors++;
            $display("FAIL flush_cycle got %b required 01100", {cur_ready, cur_valid, cur_sel});
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if ({cur_valid, cur_last, cur_sel, cur_dout} !== {5'b00000, 8'hFF} || cur_state !== IDLE) begin
            errors++;
            $display("FAIL flush_after got %h required 0ff", {cur_valid, cur_last, cur_sel, cur_dout});
        end
        check_wcnt("flush_wcnt", 8'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        words_q.push_back(8'h01);
        run(8, 1'b0);
        @(negedge clk);
        check_wcnt("flush_next_wcnt", 8'd1);
        @(posedge clk);
        #1;
        words_q.push_back(8'h7E);
        run(7, 1'b0);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if (cur_last !== 1'b1) begin
            errors++;
            $display("FAIL flush_last_pos got %b required 1", cur_last);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check_wcnt("flush_last_wcnt", 8'd1);
        exp_q.delete();
    endtask

    task automatic test_reset_mid_word();
        sel_dut = 0;
        @(posedge clk);
        #1;
        words_q.push_back(8'hA5);
        run(5, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cur_valid, cur_last, cur_sel, cur_dout, cur_wcnt} !== 21'd0 || cur_state !== IDLE) begin
            errors++;
            $display("FAIL async_reset got %h required 0", {cur_valid, cur_last, cur_sel, cur_dout, cur_wcnt});
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        sel_dut = 0;
        out_ready = 1'b1;
        for (int n = 0; n < 255; n++) words_q.push_back(8'($urandom_range(0, 255)));
        run(255 * 8, 1'b0);
        @(negedge clk);
        check_wcnt("wrap_255", 8'd255);
        @(posedge clk);
        #1;
        words_q.push_back(8'($urandom_range(0, 255)));
        run(8, 1'b0);
        @(negedge clk);
        check_wcnt("wrap_0", 8'd0);
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_stall();
        test_back_to_back();
        test_gap();
        test_flush();
        test_reset_mid_word();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
